ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter: the send side of the PS/2 port whose receive side is the `keyboard` slave. It sits on the Wishbone intercon as a slave on the same STB/ACK/WE/DAT bus as `counter`. Software writes one command byte, such as set-LEDs 0xED or reset 0xFF. The block then inhibits the bus, issues a request-to-send, shifts out an 11-bit frame on device-generated clocks, checks the device ACK bit and reports completion through a status word and an interrupt line.

## Interface
- `INHIBIT_CYCLES`, default 10000: clock-low inhibit time in `clk` cycles (100 µs at 100 MHz).
- `TIMEOUT_CYCLES`, default 2000000: frame watchdog limit in `clk` cycles (20 ms); used only with `PS2_TX_TIMEOUT_EN`.
- `clk` in 1: system clock (clk100).
- `rstn` in 1: reset; one clock, reset asynchronous and active-low.
- `STB` in 1: bus strobe from the intercon slot.
- `WE` in 1: write enable.
- `ACK` out 1: bus acknowledge.
- `DAT_I` in 32: write data; bits [7:0] are the byte to send.
- `DAT_O` out 32: status word.
- `ps2c_i` in 1: PS2C pad input (asynchronous).
- `ps2d_i` in 1: PS2D pad input (asynchronous).
- `ps2c_oe` out 1: 1 pulls PS2C low; 0 releases the line (open drain).
- `ps2d_oe` out 1: 1 pulls PS2D low; 0 releases the line.
- `busy` out 1: frame in progress; the keyboard receiver ignores frames while this is high.
- `INT` out 1: level interrupt; equals the `done` status bit.

## Operation
- Status word `DAT_O`:
  - [7:0] last byte accepted.
  - [8] busy.
  - [9] done (sticky).
  - [10] nack: device ACK bit sampled high.
  - [11] timeout.
  - [31:12] = 0.
- Write (`STB & WE`) while IDLE:
  - Latches `DAT_I[7:0]`.
  - Clears done, nack and timeout.
  - Enters INHIBIT.
- Write while not IDLE: ignored; no state change.
- Read (`STB & ~WE`): returns the status word and clears done in the same cycle. A read and a done-set in the same cycle leave done = 1.
- Parity: odd, computed as `~^byte`.
- States and transitions:
  - IDLE: both lines released; busy = 0.
  - INHIBIT: `ps2c_oe` = 1 for INHIBIT_CYCLES, then `ps2d_oe` = 1 (start bit) → START.
  - START: hold data low for one cycle, then release clock → SHIFT, with bit counter = 0.
  - SHIFT: on each synchronized falling edge of PS2C, present the next bit: data[0..7] LSB first, then parity, then stop (data released). Counter 0..9; after the stop edge → ACKWAIT.
  - ACKWAIT: on the next falling edge, sample PS2D; nack = sampled value → RECOVER.
  - RECOVER: wait until synchronized PS2C and PS2D are both high → IDLE, done = 1.
- Presenting a bit: `ps2d_oe = ~bit`.
- PS2C and PS2D are each double-flopped; the falling-edge detector compares the second flop with a third.

## Timing
- Reset values:
  - `ps2c_oe` = `ps2d_oe` = 0.
  - `busy` = 0, `INT` = 0.
  - `DAT_O` = 0.
  - State IDLE; all counters 0.
- `ACK = STB`, combinational, zero wait states.
- `busy` goes high on the cycle after the accepting write and falls in the same cycle done sets.
- The first `ps2c_oe` assertion occurs 1 cycle after the write; `ps2c_oe` stays high for exactly INHIBIT_CYCLES cycles.
- A bit change occurs 3 `clk` cycles after the pad falling edge: 2 synchronizer cycles plus 1 registered output.
- Reset asserted mid-frame releases both lines immediately (asynchronous). No partial-frame state survives reset.
- Device clock glitches shorter than 2 `clk` cycles may be counted. Filtering is not required.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined:
  - A cycle counter starts on entry to START.
  - When it reaches TIMEOUT_CYCLES in any state except IDLE, both lines are released, timeout = 1 and done = 1, and the state returns to IDLE.
- Undefined: no counter is built; the block waits indefinitely for device clocks, and bit [11] reads 0.

## Structure
- Shared package `ps2_pkg`:
  - State enum (IDLE, INHIBIT, START, SHIFT, ACKWAIT, RECOVER).
  - Status bit index constants.
  - Command constants 0xED, 0xFF, 0xF4.
- One natural sub-module, `ps2_line_sync`: 2-FF synchronizer plus falling-edge pulse for PS2C. It is reused for PS2D without the edge output.

## Test plan
- Write 0xED; the device model clocks at 12.5 kHz and ACKs low:
  - Bits observed at the device are 0, 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Status reads 0x2ED and INT = 1.
  - The next read returns 0x0ED and INT = 0.
- Write 0x00: the parity bit is 1 and the frame completes with nack = 0.
- The device model returns ACK = 1: status shows nack = 1, done = 1 (0x6xx).
- A second write of 0x55 while busy: the frame continues with the original byte, and [7:0] stays at the first value.
- Pulse `rstn` low on the 5th device clock edge: `ps2c_oe` and `ps2d_oe` are 0 in the same cycle, and the status reads 0.
- With `PS2_TX_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 5000, the device never clocks:
  - Lines are released 5000 cycles after START.
  - Status reads 0xA00 plus the byte.
  - Without the macro, `busy` stays 1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter.
package ps2_pkg;

  // Transmit sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_START   = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_ACKWAIT = 3'd4,
    ST_RECOVER = 3'd5
  } state_e;

  // Bus and status word layout.
  localparam int unsigned BUS_W        = 32;
  localparam int unsigned STAT_BYTE_W  = 8;
  localparam int unsigned STAT_BUSY    = 8;
  localparam int unsigned STAT_DONE    = 9;
  localparam int unsigned STAT_NACK    = 10;
  localparam int unsigned STAT_TIMEOUT = 11;

  // Frame bit index: 0..7 data, 8 parity, 9 stop.
  localparam int unsigned BIT_W        = 4;
  localparam logic [3:0]  BIT_PARITY   = 4'd8;
  localparam logic [3:0]  BIT_STOP     = 4'd9;

  // Common keyboard commands.
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  function automatic int unsigned ps2_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for a PS/2 pad with an optional falling-edge pulse.
module ps2_line_sync #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic line,
  output logic sync,
  output logic fall_c
);

  logic s1_q, s2_q;

  // Idle bus level is high, so the flops reset high to avoid a false edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= line;
      s2_q <= s1_q;
    end
  end

  assign sync = s2_q;

  generate
    if (EDGE_EN) begin : g_edge
      logic s3_q;

      // Third flop delays the synchronized level for edge detection.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) s3_q <= 1'b1;
        else       s3_q <= s2_q;
      end

      assign fall_c = s3_q & ~s2_q;
    end else begin : g_no_edge
      assign fall_c = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter on a Wishbone-style slave port.
// Optional frame watchdog: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             STB,
  input  logic             WE,
  output logic             ACK,
  input  logic [BUS_W-1:0] DAT_I,
  output logic [BUS_W-1:0] DAT_O,
  input  logic             ps2c_i,
  input  logic             ps2d_i,
  output logic             ps2c_oe,
  output logic             ps2d_oe,
  output logic             busy,
  output logic             INT
);

  // One counter serves the inhibit delay and, when enabled, the frame watchdog.
  localparam int unsigned CW = $clog2(ps2_max(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [7:0]       byte_q, byte_d;
  logic             c_oe_q, c_oe_d;
  logic             d_oe_q, d_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             nack_q, nack_d;
  logic             timeout_q, timeout_d;
  logic             done_set;
  logic             tx_bit;
  logic             c_sync, c_fall_c;
  logic             d_sync, d_fall_unused;
  logic             dat_hi_unused;
  logic             wr_c, rd_c;

  assign wr_c = STB & WE;
  assign rd_c = STB & ~WE;
  assign dat_hi_unused = ^DAT_I[BUS_W-1:8];

  ps2_line_sync #(.EDGE_EN(1'b1)) u_sync_c (
    .clk    (clk),
    .rstn   (rstn),
    .line   (ps2c_i),
    .sync   (c_sync),
    .fall_c (c_fall_c)
  );

  ps2_line_sync #(.EDGE_EN(1'b0)) u_sync_d (
    .clk    (clk),
    .rstn   (rstn),
    .line   (ps2d_i),
    .sync   (d_sync),
    .fall_c (d_fall_unused)
  );

  // Bit to present for the current frame position (stop and beyond read as 1).
  always_comb begin
    tx_bit = 1'b1;
    if (bit_q < BIT_PARITY)       tx_bit = byte_q[bit_q[2:0]];
    else if (bit_q == BIT_PARITY) tx_bit = ~^byte_q;
  end

  // Next-state, line drive and status update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    c_oe_d    = c_oe_q;
    d_oe_d    = d_oe_q;
    nack_d    = nack_q;
    timeout_d = timeout_q;
    done_d    = done_q;
    done_set  = 1'b0;

    if (rd_c) done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        c_oe_d = 1'b0;
        d_oe_d = 1'b0;
        if (wr_c) begin
          byte_d    = DAT_I[7:0];
          done_d    = 1'b0;
          nack_d    = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          c_oe_d    = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end
      // Clock held low; the START cycle completes the inhibit window.
      ST_INHIBIT: begin
        c_oe_d = 1'b1;
        if (cnt_q == CW'(INHIBIT_CYCLES - 2)) begin
          d_oe_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_START;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_START: begin
        c_oe_d  = 1'b0;
        bit_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (c_fall_c) begin
          d_oe_d = ~tx_bit;
          if (bit_q == BIT_STOP) state_d = ST_ACKWAIT;
          else                   bit_d   = bit_q + BIT_W'(1);
        end
      end
      ST_ACKWAIT: begin
        if (c_fall_c) begin
          nack_d  = d_sync;
          state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (c_sync && d_sync) begin
          done_set = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        c_oe_d  = 1'b0;
        d_oe_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog runs from START entry until the frame returns to IDLE.
    if (state_q != ST_IDLE && state_q != ST_INHIBIT) begin
      if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        c_oe_d    = 1'b0;
        d_oe_d    = 1'b0;
        timeout_d = 1'b1;
        done_set  = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
`endif

    // A completion in the same cycle as a read wins.
    if (done_set) done_d = 1'b1;
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset releases both lines immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      c_oe_q    <= 1'b0;
      d_oe_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      c_oe_q    <= c_oe_d;
      d_oe_q    <= d_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
      timeout_q <= timeout_d;
    end
  end

  // Status word assembled from registered state.
  always_comb begin
    DAT_O                    = '0;
    DAT_O[STAT_BYTE_W-1:0]   = byte_q;
    DAT_O[STAT_BUSY]         = busy_q;
    DAT_O[STAT_DONE]         = done_q;
    DAT_O[STAT_NACK]         = nack_q;
    DAT_O[STAT_TIMEOUT]      = timeout_q;
  end

  assign ACK     = STB;
  assign ps2c_oe = c_oe_q;
  assign ps2d_oe = d_oe_q;
  assign busy    = busy_q;
  assign INT     = done_q;

endmodule
